// File: rtl/processor_pkg.sv
// Shared processor types for the serial shift path.
//  WIDTH        register width; also the number of shifts in one Execute
//  result_t     one captured A/B result frame
//  cap_state_t  capture FSM states
package processor_pkg;

  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } result_t;

  typedef enum logic [0:0] {
    IDLE,
    SHIFT
  } cap_state_t;

endpackage

// File: rtl/result_fifo.sv
// Small result FIFO holding captured A/B frames until the consumer reads them.
//  clk_i    clock, rising edge
//  rst_ni   async active-low reset
//  push_i   write wdata_i (accepted when not full, or when a pop happens the same cycle)
//  pop_i    remove head entry (ignored when empty)
//  wdata_i  frame to write
//  rdata_o  head entry; holds the last head value while empty
//  full_o   occupancy == DEPTH
//  empty_o  occupancy == 0
//  count_o  occupancy, 0..DEPTH
module result_fifo
  import processor_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  result_t                    wdata_i,
  output result_t                    rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  result_t           mem_q [DEPTH];
  result_t           hold_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              pop_ok, push_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Pop is resolved first, so a full FIFO still takes a push in the same cycle as a pop.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // Once the FIFO drains, the read pointer lands on a stale slot; the hold register
  // keeps the last presented head visible instead.
  assign rdata_o = empty_o ? hold_q : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (!empty_o) begin
        hold_q <= mem_q[rd_ptr_q];
      end
      count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

endmodule

// File: rtl/serial_result_capture.sv
// Receive side of the serial shift path. Rebuilds WIDTH-bit A/B frames from the
// register unit's LSB-first serial outputs and queues them for parallel readout.
//  Clk        system clock, rising edge
//  Reset_n    async active-low reset
//  Shift_En   one serial bit valid on A_Bit/B_Bit
//  A_Bit      serial A stream, LSB first
//  B_Bit      serial B stream, LSB first
//  Frame_Clr  discard partial frame, return to IDLE
//  Ovf_Clr    clear sticky Overflow
//  Res_Ready  consumer accepts head entry
//  Res_Valid  FIFO non-empty
//  Res_A      head entry A value
//  Res_B      head entry B value
//  Busy       partial frame in progress
//  Overflow   sticky: a completed frame was dropped because the FIFO was full
//  Count      FIFO occupancy
// Frame width comes from processor_pkg::WIDTH so it always matches the register unit.
module serial_result_capture
  import processor_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       Shift_En,
  input  logic                       A_Bit,
  input  logic                       B_Bit,
  input  logic                       Frame_Clr,
  input  logic                       Ovf_Clr,
  input  logic                       Res_Ready,
  output logic                       Res_Valid,
  output logic [WIDTH-1:0]           Res_A,
  output logic [WIDTH-1:0]           Res_B,
  output logic                       Busy,
  output logic                       Overflow,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int unsigned BitCntW = $clog2(WIDTH);

  cap_state_t         state_q, state_d;
  logic [BitCntW-1:0] bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0]   sa_q, sa_d, sb_q, sb_d;
  logic               ovf_q, ovf_d;
  logic               push, pop, full, empty;
  result_t            push_data, head;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    push     = 1'b0;
    if (Frame_Clr) begin
      // Clear wins over a coincident shift; the bit is discarded.
      state_d  = IDLE;
      bitcnt_d = '0;
    end else if (Shift_En) begin
      sa_d = {A_Bit, sa_q[WIDTH-1:1]};
      sb_d = {B_Bit, sb_q[WIDTH-1:1]};
      case (state_q)
        IDLE: begin
          state_d  = SHIFT;
          bitcnt_d = BitCntW'(1);
        end
        SHIFT: begin
          if (bitcnt_q == BitCntW'(WIDTH - 1)) begin
            state_d  = IDLE;
            bitcnt_d = '0;
            push     = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + BitCntW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Push the next-state shift values so the final bit is part of the frame.
  assign push_data = '{a: sa_d, b: sb_d};
  assign pop       = Res_Valid & Res_Ready;

  // Set wins over clear.
  assign ovf_d = (ovf_q & ~Ovf_Clr) | (push & full & ~pop);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      ovf_q    <= ovf_d;
    end
  end

  result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_data),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (Count)
  );

  assign Res_Valid = ~empty;
  assign Res_A     = head.a;
  assign Res_B     = head.b;
  assign Busy      = (state_q == SHIFT);
  assign Overflow  = ovf_q;

endmodule
